// File: rtl/voice_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : voice_sched_pkg
//  Description : Shared types and helpers for the voice scheduler: FSM state
//                encoding, accumulator width derivation and the saturating
//                narrow used on the mixed sample.
//  Revision    : 1.0 - initial release
// ============================================================================
package voice_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SUM  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Working width for the saturation helper; wide enough for any
    // accumulator this block will be built with.
    localparam int c_sat_w = 64;

    // Accumulator needs log2(voices) growth bits plus one spare so the
    // attenuated/unattenuated sum of full-scale voices never wraps.
    function automatic int acc_width(input int width, input int voices);
        return width + $clog2(voices) + 1;
    endfunction

    // Clamp acc to the signed range of a width-bit sample. Returns the clip
    // bit; the clamped value is returned in the low width bits of value.
    function automatic logic sat_narrow(
        input  logic signed [c_sat_w-1:0] acc,
        input  int                        width,
        output logic signed [c_sat_w-1:0] value
    );
        logic signed [c_sat_w-1:0] max_v;
        logic signed [c_sat_w-1:0] min_v;
        logic                      clip;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = ~max_v;
        value = acc;
        clip  = 1'b0;
        if (acc > max_v) begin
            value = max_v;
            clip  = 1'b1;
        end else if (acc < min_v) begin
            value = min_v;
            clip  = 1'b1;
        end
        return clip;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sample_tick_gen
//  Description : Free-running sample-period counter. Counts
//                0..TICK_PERIOD-1, wraps, and flags the last count as the
//                sample tick. Never stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen
    import voice_sched_pkg::*;
#(
    parameter int TICK_PERIOD = 384
) (
    input  logic clk_i,
    input  logic reset_n_i,
    output logic tick_o
);

    localparam int                 c_cnt_w = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICK_PERIOD - 1);

    logic [c_cnt_w-1:0] r_count;

    // Period counter: wraps on the last count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign tick_o = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : voice_scheduler
//  Description : Once per sample period, requests one sample from each
//                enabled voice, sums the captures sequentially in a single
//                accumulator, saturates to sample width and hands the result
//                to the I2S side on a valid/ready handshake. Sticky status
//                flags report voice timeouts, dropped ticks and clipping.
//  Options     : VOICE_SCHED_ATTEN_EN adds atten_i, a 2-bit per-voice
//                arithmetic right shift applied before accumulation.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_scheduler
    import voice_sched_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int VOICES      = 4,
    parameter int TICK_PERIOD = 384,
    parameter int TIMEOUT     = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [VOICES-1:0]       enable_i,
`ifdef VOICE_SCHED_ATTEN_EN
    input  logic [2*VOICES-1:0]     atten_i,
`endif
    output logic [VOICES-1:0]       voice_ready_o,
    input  logic [VOICES-1:0]       voice_valid_i,
    input  logic [VOICES*WIDTH-1:0] voice_data_i,
    output logic [WIDTH-1:0]        sample_data_o,
    output logic                    sample_valid_o,
    input  logic                    sample_ready_i,
    input  logic                    clear_i,
    output logic                    underrun_o,
    output logic                    overrun_o,
    output logic                    clip_o
);

    localparam int                 c_acc_w    = acc_width(WIDTH, VOICES);
    localparam int                 c_idx_w    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int                 c_to_w     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(VOICES - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT - 1);

    state_e                     r_state;
    state_e                     w_state_next;
    logic                       w_tick;
    logic [VOICES-1:0]          r_en_q;
    logic [VOICES-1:0]          r_captured;
    logic [c_to_w-1:0]          r_to_cnt;
    logic [c_idx_w-1:0]         r_idx;
    logic signed [c_acc_w-1:0]  r_acc;
    logic [VOICES-1:0]          w_xfer;
    logic                       w_all_done;
    logic                       w_timeout;
    logic                       w_req_exit;
    logic                       w_sum_last;
    logic [VOICES*WIDTH-1:0]    w_hold_flat;
    logic signed [WIDTH-1:0]    w_hold_sel;
    logic [1:0]                 w_shift;
    logic signed [WIDTH-1:0]    w_hold_sh;
    logic signed [c_acc_w-1:0]  w_acc_next;
    logic signed [c_sat_w-1:0]  w_sat_wide;
    logic                       w_sat_clip;
    logic [WIDTH-1:0]           w_sat_data;
    logic [WIDTH-1:0]           r_sample_data;
    logic                       r_sample_valid;
    logic                       r_underrun;
    logic                       r_overrun;
    logic                       r_clip;
    logic                       w_set_underrun;
    logic                       w_set_overrun;
    logic                       w_set_clip;

    sample_tick_gen #(
        .TICK_PERIOD (TICK_PERIOD)
    ) u_tick (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .tick_o    (w_tick)
    );

    // ------------------------------------------------------------------
    // Request / capture handshake
    // ------------------------------------------------------------------
    assign voice_ready_o = (r_state == REQ) ? (r_en_q & ~r_captured) : '0;
    assign w_xfer        = voice_ready_o & voice_valid_i;
    // Same-cycle captures count, so a voice that answers on the last
    // outstanding request lets REQ exit without an extra cycle.
    assign w_all_done    = &(r_captured | w_xfer | ~r_en_q);
    assign w_timeout     = (r_to_cnt == c_to_last);
    assign w_req_exit    = (r_state == REQ) && (w_all_done || w_timeout);
    assign w_sum_last    = (r_state == SUM) && (r_idx == c_idx_last);

    // ------------------------------------------------------------------
    // Sequential sum datapath
    // ------------------------------------------------------------------
    assign w_hold_sel = w_hold_flat[r_idx*WIDTH +: WIDTH];

`ifdef VOICE_SCHED_ATTEN_EN
    logic [2*VOICES-1:0] r_atten;

    // Attenuation is frozen for the whole sample, like the enables.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_atten <= '0;
        end else if (r_state == IDLE && w_tick) begin
            r_atten <= atten_i;
        end
    end

    assign w_shift = r_atten[{r_idx, 1'b0} +: 2];
`else
    assign w_shift = 2'd0;
`endif

    assign w_hold_sh  = w_hold_sel >>> w_shift;
    assign w_acc_next = r_acc + c_acc_w'(w_hold_sh);

    // Saturate the final accumulator value down to sample width.
    always_comb begin
        w_sat_wide = '0;
        w_sat_clip = sat_narrow(c_sat_w'(w_acc_next), WIDTH, w_sat_wide);
    end

    assign w_sat_data = WIDTH'(w_sat_wide);

    // ------------------------------------------------------------------
    // Per-voice hold registers: zeroed at sample start so disabled and
    // timed-out voices contribute nothing.
    // ------------------------------------------------------------------
    generate
        for (genvar v = 0; v < VOICES; v++) begin : g_voice
            logic [WIDTH-1:0] r_hold;

            // Capture voice v on its ready/valid transfer.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_hold <= '0;
                end else if (r_state == IDLE && w_tick) begin
                    r_hold <= '0;
                end else if (w_xfer[v]) begin
                    r_hold <= voice_data_i[v*WIDTH +: WIDTH];
                end
            end

            assign w_hold_flat[v*WIDTH +: WIDTH] = r_hold;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; ticks outside IDLE are simply not acted on.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_tick)                            w_state_next = REQ;
            REQ:     if (w_req_exit)                        w_state_next = SUM;
            SUM:     if (w_sum_last)                        w_state_next = OUT;
            OUT:     if (r_sample_valid && sample_ready_i)  w_state_next = IDLE;
            default:                                        w_state_next = IDLE;
        endcase
    end

    // Per-sample request bookkeeping: latch enables, track captures and
    // the REQ timeout.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_en_q     <= '0;
            r_captured <= '0;
            r_to_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_en_q     <= enable_i;
                        r_captured <= '0;
                        r_to_cnt   <= '0;
                    end
                end
                REQ: begin
                    r_captured <= r_captured | w_xfer;
                    r_to_cnt   <= r_to_cnt + c_to_w'(1);
                end
                default: ;
            endcase
        end
    end

    // Accumulator and voice index: cleared on REQ exit, one voice per SUM cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_req_exit) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (r_state == SUM) begin
            r_acc <= w_acc_next;
            r_idx <= r_idx + c_idx_w'(1);
        end
    end

    // Output holding register: loaded on the last SUM cycle, held until taken.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
        end else if (w_sum_last) begin
            r_sample_data  <= w_sat_data;
            r_sample_valid <= 1'b1;
        end else if (r_state == OUT && r_sample_valid && sample_ready_i) begin
            r_sample_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags: a set in the same cycle as clear_i wins.
    // ------------------------------------------------------------------
    assign w_set_underrun = w_req_exit && !w_all_done;
    assign w_set_overrun  = w_tick && (r_state != IDLE);
    assign w_set_clip     = w_sum_last && w_sat_clip;

    // Flag registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
            r_clip     <= 1'b0;
        end else begin
            r_underrun <= w_set_underrun | (r_underrun & ~clear_i);
            r_overrun  <= w_set_overrun  | (r_overrun  & ~clear_i);
            r_clip     <= w_set_clip     | (r_clip     & ~clear_i);
        end
    end

    assign sample_data_o  = r_sample_data;
    assign sample_valid_o = r_sample_valid;
    assign underrun_o     = r_underrun;
    assign overrun_o      = r_overrun;
    assign clip_o         = r_clip;

endmodule
`default_nettype wire

// File: tb/tb_voice_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_scheduler
//  Description : Directed self-checking bench for voice_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  enable = 4'hF;
    logic [3:0]  voice_ready;
    logic [3:0]  voice_valid = 4'hF;
    logic [63:0] voice_data = '0;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        clear = 1'b0;
    logic        underrun;
    logic        overrun;
    logic        clip;
`ifdef VOICE_SCHED_ATTEN_EN
    logic [7:0]  atten = '0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    voice_scheduler dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .enable_i       (enable),
`ifdef VOICE_SCHED_ATTEN_EN
        .atten_i        (atten),
`endif
        .voice_ready_o  (voice_ready),
        .voice_valid_i  (voice_valid),
        .voice_data_i   (voice_data),
        .sample_data_o  (sample_data),
        .sample_valid_o (sample_valid),
        .sample_ready_i (sample_ready),
        .clear_i        (clear),
        .underrun_o     (underrun),
        .overrun_o      (overrun),
        .clip_o         (clip)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
        voice_data = {d3, d2, d1, d0};
    endtask

    task automatic wait_ready(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            if (voice_ready !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_sample(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            if (sample_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (voice_ready !== 4'b0000) begin errors++; $display("FAIL reset_voice_ready got=%b exp=0000", voice_ready); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got=%b exp=0", sample_valid); end
        checks++; if (sample_data !== 16'h0000) begin errors++; $display("FAIL reset_sample_data got=%h exp=0000", sample_data); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL reset_clip got=%b exp=0", clip); end
        reset_n = 1'b1;
    endtask

    task automatic test_nominal();
        bit ok;
        int t0;
        int lat;
        set_data(16'd100, 16'd200, 16'd300, 16'd400);
        voice_valid  = 4'hF;
        enable       = 4'hF;
        sample_ready = 1'b1;
        wait_ready(800, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nominal_req got=timeout exp=request"); end
        t0 = cyc;
        checks++; if (voice_ready !== 4'b1111) begin errors++; $display("FAIL nominal_ready got=%b exp=1111", voice_ready); end
        @(negedge clk);
        checks++; if (voice_ready !== 4'b0000) begin errors++; $display("FAIL nominal_ready_pulse got=%b exp=0000", voice_ready); end
        lat = 1;
        while (sample_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 5) begin errors++; $display("FAIL nominal_latency got=%0d exp=5", lat); end
        checks++; if (sample_data !== 16'd1000) begin errors++; $display("FAIL nominal_data got=%0d exp=1000", $signed(sample_data)); end
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL nominal_valid_drop got=%b exp=0", sample_valid); end
        wait_ready(800, ok);
        checks++; if (cyc - t0 != 384) begin errors++; $display("FAIL nominal_period got=%0d exp=384", cyc - t0); end
        wait_sample(50, ok);
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit ok;
        set_data(16'd16000, 16'd16000, 16'd16000, 16'd16000);
        wait_sample(800, ok);
        checks++; if (sample_data !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%0d exp=32767", $signed(sample_data)); end
        checks++; if (clip !== 1'b1) begin errors++; $display("FAIL sat_clip got=%b exp=1", clip); end
        @(negedge clk);
        set_data(-16'sd16000, -16'sd16000, -16'sd16000, -16'sd16000);
        wait_sample(800, ok);
        checks++; if (sample_data !== 16'h8000) begin errors++; $display("FAIL sat_neg got=%0d exp=-32768", $signed(sample_data)); end
        @(negedge clk);
        pulse_clear();
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL sat_clear got=%b exp=0", clip); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        set_data(16'd1000, 16'd1000, 16'd1000, 16'd1000);
        voice_valid = 4'b1011;
        wait_ready(800, ok);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (voice_ready !== 4'b0000) n++;
            else break;
        end
        checks++; if (n != 64) begin errors++; $display("FAIL timeout_req_len got=%0d exp=64", n); end
        wait_sample(50, ok);
        checks++; if (sample_data !== 16'd3000) begin errors++; $display("FAIL timeout_data got=%0d exp=3000", $signed(sample_data)); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL timeout_underrun got=%b exp=1", underrun); end
        @(negedge clk);
        pulse_clear();
        voice_valid = 4'hF;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        int t_req0;
        int t_x;
        int k;
        logic [15:0] d0;
        set_data(16'd100, 16'd200, 16'd300, 16'd400);
        sample_ready = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun_pre got=%b exp=0", overrun); end
        wait_ready(800, ok);
        t_req0 = cyc;
        wait_sample(50, ok);
        d0 = sample_data;
        checks++; if (d0 !== 16'd1000) begin errors++; $display("FAIL bp_data got=%0d exp=1000", $signed(d0)); end
        stable = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (sample_valid !== 1'b1 || sample_data !== 16'd1000) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable got=%b exp=1", stable); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
        sample_ready = 1'b1;
        @(negedge clk);
        t_x = cyc;
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL bp_single_xfer got=%b exp=0", sample_valid); end
        k = 1;
        while (t_req0 + 384 * k <= t_x) k++;
        wait_ready(800, ok);
        checks++; if (cyc != t_req0 + 384 * k) begin errors++; $display("FAIL bp_next_req got=%0d exp=%0d", cyc, t_req0 + 384 * k); end
        wait_sample(50, ok);
        @(negedge clk);
    endtask

    task automatic test_enables();
        bit ok;
        bit seen;
        enable = 4'b0000;
        seen = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (voice_ready !== 4'b0000) seen = 1'b1;
            if (sample_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL en_none_ready got=%b exp=0", seen); end
        checks++; if (!ok || sample_data !== 16'd0) begin errors++; $display("FAIL en_none_data got=%0d exp=0", $signed(sample_data)); end
        @(negedge clk);
        enable = 4'hF;
        voice_valid = 4'b0111;
        set_data(16'd100, 16'd200, 16'd300, 16'd400);
        wait_ready(800, ok);
        enable = 4'b0111;
        @(negedge clk);
        checks++; if (voice_ready !== 4'b1000) begin errors++; $display("FAIL en_toggle_ready got=%b exp=1000", voice_ready); end
        voice_valid = 4'hF;
        wait_sample(100, ok);
        checks++; if (sample_data !== 16'd1000) begin errors++; $display("FAIL en_toggle_data got=%0d exp=1000", $signed(sample_data)); end
        @(negedge clk);
        enable = 4'hF;
    endtask

    task automatic test_reset_mid_sum();
        bit ok;
        int n;
        set_data(16'd100, 16'd200, 16'd300, 16'd400);
        voice_valid  = 4'hF;
        sample_ready = 1'b1;
        wait_ready(800, ok);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (voice_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready got=%b exp=0000", voice_ready); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", sample_valid); end
        checks++; if (sample_data !== 16'h0000) begin errors++; $display("FAIL rst_mid_data got=%h exp=0000", sample_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun got=%b exp=0", overrun); end
        checks++; if (underrun !== 1'b0 || clip !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got=%b%b exp=00", underrun, clip); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            n++;
            if (sample_valid === 1'b1) break;
        end
        checks++; if (n != 389) begin errors++; $display("FAIL rst_first_valid got=%0d exp=389", n); end
        checks++; if (sample_data !== 16'd1000) begin errors++; $display("FAIL rst_first_data got=%0d exp=1000", $signed(sample_data)); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_saturation();
        test_timeout();
        test_backpressure();
        test_enables();
        test_reset_mid_sum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
